// File: rtl/alu_result_stage.sv
// Writeback stage behind the ALU: buffers results in a small FIFO, tracks Z/N/C,
// and hands entries to the register-file write port over valid/ready.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           alu_out,
  input  logic                       carry_out,
  input  logic [2:0]                 alu_sel,
  input  logic [AW-1:0]              rd_addr,
  input  logic                       flag_clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           wb_data,
  output logic [AW-1:0]              wb_addr,
  output logic [$clog2(DEPTH):0]     wb_count,
  output logic                       flag_z,
  output logic                       flag_n,
  output logic                       flag_c
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [2:0]    SEL_ADD = 3'b000;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [AW-1:0]    addr_mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             push, pop;

  // in_ready depends only on registered occupancy, so a full FIFO never
  // accepts in the same cycle it drains.
  assign in_ready  = (count < DEPTH_C) && !rst;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign wb_count  = count;
  assign wb_data   = out_valid ? data_mem[rptr] : '0;
  assign wb_addr   = out_valid ? addr_mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wptr] <= alu_out;
      addr_mem[wptr] <= rd_addr;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow gives the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else if (flag_clr) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else if (push) begin
      flag_z <= (alu_out == '0);
      flag_n <= alu_out[WIDTH-1];
      flag_c <= (alu_sel == SEL_ADD) ? carry_out : 1'b0;
    end
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered writeback stage directly downstream of the combinational ALU. Captures ALU_Out, CarryOut and the operation code each cycle a result is offered, and buffers them in a small FIFO. Updates a Z/N/C status-flag register and presents results to the register-file write port through a valid/ready handshake. Decouples ALU issue from register-file write stalls.

Parameters:
WIDTH, 32, datapath width; matches the ALU operand/result width.
AW, 5, destination register address width.
DEPTH, 2, FIFO entries; power of 2, minimum 2.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  ALU result offered this cycle.
in_ready  out  1  stage can accept a result.
alu_out  in  WIDTH  ALU result (ALU_Out).
carry_out  in  1  ALU carry (CarryOut).
alu_sel  in  3  opcode that produced alu_out.
rd_addr  in  AW  destination register.
flag_clr  in  1  synchronous clear of all flags.
out_valid  out  1  head entry valid.
out_ready  in  1  register file accepts the head entry.
wb_data  out  WIDTH  head result.
wb_addr  out  AW  head destination.
wb_count  out  clog2(DEPTH)+1  current occupancy.
flag_z  out  1  zero flag.
flag_n  out  1  negative flag.
flag_c  out  1  carry flag.

Behaviour:
- Reset (async, rst=1): count=0, read/write pointers=0, out_valid=0, wb_data=0, wb_addr=0, wb_count=0, flag_z/n/c=0, in_ready=0 while rst is held. FIFO storage contents need not be reset.
- in_ready = (count < DEPTH) and not rst. It is combinational from registered count only, never from out_ready. A full FIFO therefore does not accept a push in the same cycle as a pop.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- On push, {alu_out, rd_addr} is written at wptr, and wptr increments modulo DEPTH (wraps).
- On pop, rptr increments modulo DEPTH (wraps).
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: a result pushed in cycle N is visible on wb_data/wb_addr with out_valid=1 in cycle N+1. There is no combinational bypass.
- out_valid = (count != 0).
- wb_data/wb_addr show the head entry when out_valid=1, and 0 when the FIFO is empty.
- wb_count = count.
- Inputs with in_valid=0 are ignored. in_valid held while in_ready=0 is not a transfer; the producer keeps data stable.
- Flags update in the cycle after a push, from the pushed values:
  - flag_z = (alu_out == 0).
  - flag_n = alu_out[WIDTH-1].
  - flag_c = carry_out when alu_sel == 3'b000 (add); otherwise flag_c = 0 (CarryOut is only meaningful for add).
- Flags hold their value when there is no push.
- flag_clr=1 forces all flags to 0 on the next edge and has priority over a simultaneous push's flag update. The push itself still stores its data.
- Pop does not affect flags.
- Reset mid-operation: any buffered entries are discarded. out_valid drops immediately (async) and stays 0 until a new push completes after rst deasserts.
- Unused opcodes (e.g. 3'b100) are treated as ordinary results. Flags follow the Z/N rules, and C=0.

Test Plan:
- Reset: assert rst mid-stream with 2 entries buffered -> out_valid, wb_data, wb_count and all flags read 0 immediately; in_ready=0 during rst and 1 the cycle after release.
- Single transfer: push alu_out=0x0000_0005, rd_addr=3, sel=000, carry=0 -> next cycle out_valid=1, wb_data=5, wb_addr=3, wb_count=1, Z=0, N=0, C=0; with out_ready=1, the following cycle out_valid=0.
- Fill/backpressure: out_ready=0, push 0x11 then 0x22 -> wb_count=2, in_ready=0, and a third offer of 0x33 is not accepted. Raise out_ready -> 0x11 then 0x22 appear in order, and in_ready returns to 1 after the first pop.
- Simultaneous push/pop at count=1 with pointer wrap (run 5 transfers) -> wb_count stays 1, and data order is preserved across the wrap.
- Flags: push alu_out=0x0000_0000, carry=1, sel=000 -> Z=1, C=1, N=0. Then push 0x8000_0000, carry=1, sel=001 -> Z=0, N=1, C=0.
- Flag clear: flag_clr=1 in the same cycle as a push of 0 with carry=1, sel=000 -> flags all 0 next cycle, and the entry is still delivered with wb_data=0.
